// File: rtl/cipher_seq_pkg.sv
// Shared types and constants for the cipher sequencer and its round counter.
package cipher_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ENC       = 1'b0;
  localparam logic MODE_DEC       = 1'b1;
  localparam int   DEFAULT_ROUNDS = 4;

endpackage

// File: rtl/cipher_sequencer_round_counter.sv
// Loadable up/down round index counter that saturates at its terminal index.
module round_counter
  import cipher_seq_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS,
  parameter int RIDX_W = $clog2(ROUNDS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_load,
  input  logic              i_mode,
  input  logic              i_step,
  output logic [RIDX_W-1:0] o_count,
  output logic              o_terminal
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

  logic [RIDX_W-1:0] r_count;
  logic              r_dec;
  logic              w_terminal;

  // Direction is captured at load so a later mode change cannot redirect the count.
  assign w_terminal = r_dec ? (r_count == '0) : (r_count == LAST_IDX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_dec   <= 1'b0;
    end else if (i_load) begin
      r_dec   <= (i_mode == MODE_DEC);
      r_count <= (i_mode == MODE_DEC) ? LAST_IDX : '0;
    end else if (i_step && !w_terminal) begin
      r_count <= r_dec ? (r_count - 1'b1) : (r_count + 1'b1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = w_terminal;

endmodule

// File: rtl/cipher_sequencer.sv
// Accepts one block, drives the round datapath through all rounds, and holds the result.
module cipher_sequencer
  import cipher_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROUNDS = DEFAULT_ROUNDS,
  parameter int RIDX_W = $clog2(ROUNDS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Mode,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              DpLoad,
  output logic [DATA_W-1:0] DpData,
  output logic              DpStep,
  output logic [RIDX_W-1:0] DpRound,
  output logic              DpMode,
  input  logic [DATA_W-1:0] DpResult,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Aborted
);

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_dp_data;
  logic              r_dp_mode;
  logic [DATA_W-1:0] r_out_data;
  logic              r_done_first;
  logic              r_aborted;
  logic              w_accept;
  logic              w_abort;
  logic              w_terminal;
  logic              w_step;

  round_counter #(.ROUNDS(ROUNDS), .RIDX_W(RIDX_W)) u_round_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_load     (r_state == LOAD),
    .i_mode     (r_dp_mode),
    .i_step     (w_step),
    .o_count    (DpRound),
    .o_terminal (w_terminal)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    InReady      = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        InReady  = Active && !Reset;
        w_accept = InValid && Active && !Reset;
        if (w_accept) w_state_next = LOAD;
      end
      LOAD: begin
        w_abort      = !Active;
        w_state_next = Active ? RUN : IDLE;
      end
      RUN: begin
        w_step  = Active;
        w_abort = !Active;
        if (!Active)        w_state_next = IDLE;
        else if (w_terminal) w_state_next = DONE;
      end
      DONE: begin
        if (OutReady) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_dp_data    <= '0;
      r_dp_mode    <= 1'b0;
      r_out_data   <= '0;
      r_done_first <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_aborted    <= w_abort;
      r_done_first <= (r_state == RUN) && (w_state_next == DONE);
      if (w_accept) begin
        r_dp_data <= InData;
        r_dp_mode <= Mode;
      end
      if (r_done_first) r_out_data <= DpResult;
    end
  end

  // The last round lands in DpResult during the first DONE cycle, so pass it
  // through then and serve the captured copy afterwards.
  assign OutData  = r_done_first ? DpResult : r_out_data;
  assign OutValid = (r_state == DONE);
  assign DpLoad   = (r_state == LOAD);
  assign DpStep   = w_step;
  assign DpData   = r_dp_data;
  assign DpMode   = r_dp_mode;
  assign Busy     = (r_state != IDLE);
  assign Aborted  = r_aborted;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Directed self-checking bench for cipher_sequencer with a behavioural round datapath.
module tb_cipher_sequencer;

  logic       Clk, Reset, Active, Mode, InValid, InReady;
  logic [7:0] InData, DpData, DpResult, OutData;
  logic       DpLoad, DpStep, DpMode, OutValid, OutReady, Busy, Aborted;
  logic [1:0] DpRound;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic [7:0] dp_state;

  cipher_sequencer #(.DATA_W(8), .ROUNDS(4), .RIDX_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .DpLoad(DpLoad), .DpData(DpData), .DpStep(DpStep), .DpRound(DpRound),
    .DpMode(DpMode), .DpResult(DpResult), .OutValid(OutValid),
    .OutReady(OutReady), .OutData(OutData), .Busy(Busy), .Aborted(Aborted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] round_fn(input logic [7:0] s, input logic [1:0] r, input logic m);
    return ({s[6:0], s[7]} ^ {4'h5, m, 1'b0, r}) + 8'h13;
  endfunction

  function automatic logic [7:0] expect_result(input logic [7:0] d, input logic m);
    logic [7:0] s;
    s = d;
    for (int i = 0; i < 4; i++) s = round_fn(s, m ? 2'(3 - i) : 2'(i), m);
    return s;
  endfunction

  // Behavioural round datapath driven by the sequencer.
  always_ff @(posedge Clk) begin
    if (DpLoad)      dp_state <= DpData;
    else if (DpStep) dp_state <= round_fn(dp_state, DpRound, DpMode);
  end
  assign DpResult = dp_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, InReady, 0);
    chk({tag, "_dp_load"}, DpLoad, 0);
    chk({tag, "_dp_step"}, DpStep, 0);
    chk({tag, "_out_valid"}, OutValid, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_aborted"}, Aborted, 0);
    chk({tag, "_dp_round"}, DpRound, 0);
    chk({tag, "_dp_mode"}, DpMode, 0);
    chk({tag, "_dp_data"}, DpData, 0);
    chk({tag, "_out_data"}, OutData, 0);
  endtask

  // One full block: accept, load, ROUNDS steps, result, handshake.
  task automatic do_block(input logic [7:0] d, input logic m, input int hold, input bit toggle);
    logic [7:0] exp;
    int bad;
    @(negedge Clk);
    InData = d; Mode = m; InValid = 1'b1; OutReady = 1'b0;
    #1 chk("accept_ready", InReady, 1);
    sb.push_back(expect_result(d, m));
    $display("accept data=%0h mode=%0d", d, m);
    @(negedge Clk);
    InValid = 1'b0;
    if (toggle) Mode = ~m;
    #1;
    chk("load_pulse", DpLoad, 1);
    chk("load_data", DpData, d);
    chk("load_mode", DpMode, m);
    chk("load_busy", Busy, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (toggle) Mode = ~Mode;
      #1;
      chk("run_step", DpStep, 1);
      chk("run_round", DpRound, m ? 3 - i : i);
      chk("run_mode", DpMode, m);
    end
    @(negedge Clk);
    OutReady = (hold == 0);
    #1 chk("done_valid", OutValid, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      exp = 8'h00;
    end else exp = sb.pop_front();
    chk("done_data", OutData, exp);
    $display("result data=%0h exp=%0h", OutData, exp);
    if (hold > 0) begin
      bad = 0;
      for (int k = 0; k < hold; k++) begin
        @(negedge Clk);
        InValid = 1'b1; InData = 8'hFF;
        #1 if (OutValid !== 1'b1 || OutData !== exp || InReady !== 1'b0) bad++;
      end
      chk("done_hold_stable", bad, 0);
      OutReady = 1'b1;
    end
    @(negedge Clk);
    InValid = 1'b0;
    #1;
    chk("post_valid", OutValid, 0);
    chk("post_busy", Busy, 0);
  endtask

  initial begin
    int cnt, ov;
    Reset = 1'b1; Active = 1'b0; Mode = 1'b0; InValid = 1'b0;
    InData = 8'h00; OutReady = 1'b1;
    repeat (2) @(negedge Clk);
    #1 chk_reset_vals("reset");
    @(negedge Clk);
    Reset = 1'b0; Active = 1'b1;
    #1 chk("idle_ready", InReady, 1);

    do_block(8'hA5, 1'b0, 0, 1'b0);
    do_block(8'h3C, 1'b1, 0, 1'b1);

    // Locked: no acceptance while Active is low.
    Active = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      InValid = 1'b1; InData = 8'h77;
      #1 if (InReady !== 1'b0 || DpLoad !== 1'b0) cnt++;
    end
    chk("locked_no_accept", cnt, 0);
    InValid = 1'b0; Active = 1'b1;

    // Abort at the second round step.
    @(negedge Clk);
    InData = 8'h5A; Mode = 1'b0; InValid = 1'b1;
    #1 chk("abort_accept", InReady, 1);
    @(negedge Clk);
    InValid = 1'b0;
    @(negedge Clk);
    #1 chk("abort_step1", DpRound, 0);
    @(negedge Clk);
    Active = 1'b0;
    #1 chk("abort_step_off", DpStep, 0);
    cnt = int'(Aborted); ov = int'(OutValid);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      #1;
      if (k == 0) chk("abort_idle", Busy, 0);
      cnt += int'(Aborted); ov += int'(OutValid);
    end
    chk("abort_pulses", cnt, 1);
    chk("abort_no_valid", ov, 0);
    $display("abort pulses=%0d", cnt);
    Active = 1'b1;
    do_block(8'hC3, 1'b0, 0, 1'b0);

    // Backpressure in DONE.
    do_block(8'h96, 1'b1, 10, 1'b0);

    // Reset during RUN.
    @(negedge Clk);
    InData = 8'h81; Mode = 1'b1; InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    #1 chk_reset_vals("midrun_reset");
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      #1 cnt += int'(Aborted) + int'(Busy);
    end
    chk("reset_no_abort", cnt, 0);
    do_block(8'h12, 1'b0, 0, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cipher_sequencer.md
# cipher_sequencer

Sequences the round-based cipher datapath once the key-entry controller has unlocked the design. Accepts one data block per valid/ready handshake, latches the requested mode, and steps the external round unit through ROUNDS rounds with the correct round index ordering. It then holds the result on a valid/ready output port. It sits between the key-entry controller (Active, Mode) and the round datapath.

## Interface
- DATA_W, 8, width of data block and datapath result
- ROUNDS, 4, number of round steps per block (≥2)
- RIDX_W, $clog2(ROUNDS), width of round index
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Active  in  1  unlock flag from key-entry controller; blocks accepted only while 1
- Mode  in  1  0 = encrypt, 1 = decrypt; sampled at block acceptance
- InValid  in  1  input block valid
- InReady  out  1  input block ready
- InData  in  DATA_W  input block
- DpLoad  out  1  one-cycle pulse: datapath loads DpData
- DpData  out  DATA_W  registered copy of accepted InData
- DpStep  out  1  datapath executes one round this cycle
- DpRound  out  RIDX_W  round index for current step
- DpMode  out  1  latched mode for current block
- DpResult  in  DATA_W  datapath state, valid the cycle after the last DpStep
- OutValid  out  1  result valid
- OutReady  in  1  result consumer ready
- OutData  out  DATA_W  captured result
- Busy  out  1  high in LOAD, RUN, DONE
- Aborted  out  1  one-cycle pulse when a block is dropped

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: InReady = Active (combinational, IDLE only). On InValid && InReady, latch InData→DpData and Mode→DpMode, then go to LOAD.
- LOAD: DpLoad = 1 for one cycle. Preload the round counter to 0 (encrypt) or ROUNDS-1 (decrypt). Go to RUN.
- RUN: DpStep = 1 every cycle. DpRound = counter. Counter increments for encrypt and decrements for decrypt. After exactly ROUNDS step cycles (terminal index ROUNDS-1 for encrypt, 0 for decrypt), go to DONE.
- DONE entry: capture DpResult→OutData and set OutValid = 1. Hold OutData stable until OutValid && OutReady, then clear OutValid and go to IDLE.
- Abort: if Active = 0 while in LOAD or RUN, go to IDLE next cycle and pulse Aborted for 1 cycle. No OutValid is produced and DpStep is deasserted immediately.
- Active = 0 during DONE does not abort. The result is still delivered.
- Mode changes after acceptance have no effect on the current block.
- Counter never wraps: it is reloaded in LOAD and stops at the terminal index.

## Timing
- Reset values: InReady 0 (follows Active in IDLE after reset). DpLoad, DpStep, OutValid, Busy and Aborted are 0. DpRound 0, DpMode 0, DpData 0, OutData 0. State is IDLE.
- Acceptance at edge t. DpLoad high in cycle t+1. DpStep high in cycles t+2 … t+ROUNDS+1. OutValid rises at t+ROUNDS+2.
- Throughput is one block per ROUNDS+3 cycles with OutReady tied high. There is no overlap, and no accept in the same cycle as the DONE→IDLE handshake.
- OutValid, once set, stays high until the handshake completes, regardless of Active or InValid.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous). Any in-flight block is lost without an Aborted pulse.

## Structure
- Shared package cipher_seq_pkg holds the state enum (IDLE, LOAD, RUN, DONE), MODE_ENC = 1'b0, MODE_DEC = 1'b1, and the default ROUNDS.
- One sub-module, round_counter: a loadable up/down counter, RIDX_W wide, with a terminal-index flag. The FSM, handshake and data registers live in cipher_sequencer.

## Test plan
- Reset, then Active = 1, Mode = 0, InData = 8'hA5, OutReady = 1 → DpLoad at t+1; DpRound 0,1,2,3 across t+2..t+5; OutValid at t+6 with OutData = DpResult.
- Mode = 1 block → DpRound 3,2,1,0 with DpMode = 1. Toggling Mode during RUN leaves DpMode unchanged.
- Active = 0 with InValid = 1 → InReady = 0 and no DpLoad for 20 cycles.
- Active drops at the second DpStep → Aborted pulses once, state IDLE next cycle, OutValid never rises. A new block is accepted after Active returns.
- OutReady = 0 for 10 cycles in DONE → OutValid and OutData stable and InReady = 0. Raising OutReady completes the handshake and returns to IDLE.
- Reset asserted mid-RUN → all outputs at reset values the same cycle, and the next block runs the full sequence from round 0.
